// File: rtl/sar_search_3b.sv
// 3-bit successive-approximation search: probes an external comparator
// and narrows [lo, hi] until it finds the hidden operand or detects an
// inconsistent answer.
module sar_search_3b (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       ack,
   input  logic       eq,
   input  logic       lt,
   input  logic       gt,
   output logic       req,
   output logic [2:0] guess,
   output logic       busy,
   output logic       done,
   output logic       err,
   output logic [2:0] result,
   output logic [2:0] probes
);

   // state | meaning
   // IDLE  | waiting for start after reset
   // REQ   | probe outstanding, guess valid, waiting for ack
   // DONE  | result holds the found value
   // ERR   | search aborted on an illegal or contradictory answer
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_DONE = 2'd2,
      ST_ERR  = 2'd3
   } state_t;

   state_t     state, state_nxt;
   logic [3:0] lo, hi, lo_nxt, hi_nxt;
   logic [3:0] sum, mid;

   // Bounds are 4 bits wide so guess+1 = 8 cannot wrap back into range
   assign sum = lo + hi;
   assign mid = {1'b0, sum[3:1]};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      lo_nxt    = lo;
      hi_nxt    = hi;
      case (state)
         ST_REQ: begin
            if (ack) begin
               case ({eq, lt, gt})
                  3'b100: state_nxt = ST_DONE;
                  3'b010: begin
                     lo_nxt = mid + 4'd1;
                     if (lo_nxt > hi) state_nxt = ST_ERR;
                  end
                  3'b001: begin
                     if (mid == 4'd0) begin
                        state_nxt = ST_ERR;
                     end else begin
                        hi_nxt = mid - 4'd1;
                        if (lo > hi_nxt) state_nxt = ST_ERR;
                     end
                  end
                  default: state_nxt = ST_ERR;
               endcase
            end
         end
         default: begin
            if (start) state_nxt = ST_REQ;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lo     <= 4'd0;
         hi     <= 4'd7;
         probes <= 3'd0;
         result <= 3'd0;
      end else if (state != ST_REQ) begin
         if (start) begin
            lo     <= 4'd0;
            hi     <= 4'd7;
            probes <= 3'd0;
            result <= 3'd0;
         end
      end else if (ack) begin
         probes <= probes + 3'd1;
         lo     <= lo_nxt;
         hi     <= hi_nxt;
         if (state_nxt == ST_DONE) result <= mid[2:0];
      end
   end

   always_comb begin
      req   = (state == ST_REQ);
      busy  = (state == ST_REQ);
      done  = (state == ST_DONE);
      err   = (state == ST_ERR);
      guess = (state == ST_REQ) ? mid[2:0] : 3'd0;
   end

endmodule

// File: tb/tb_sar_search_3b.sv
// Self-checking bench for sar_search_3b: a responder answers each probe
// from a secret, and expected guesses are queued and popped per probe.
module tb_sar_search_3b;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       ack = 1'b0;
   logic       eq = 1'b0, lt = 1'b0, gt = 1'b0;
   logic       req, busy, done, err;
   logic [2:0] guess, result, probes;

   int passed = 0;
   int total  = 0;
   int exp_q[$];

   sar_search_3b dut (
      .clk(clk), .rst(rst), .start(start), .ack(ack),
      .eq(eq), .lt(lt), .gt(gt),
      .req(req), .guess(guess), .busy(busy), .done(done), .err(err),
      .result(result), .probes(probes)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_idle_outputs(input string name);
      total++;
      if ({req, busy, done, err, guess, result, probes} !== 13'd0)
         $display("FAIL %s: req=%0b busy=%0b done=%0b err=%0b guess=%0d result=%0d probes=%0d, required all 0",
                  name, req, busy, done, err, guess, result, probes);
      else passed++;
   endtask

   // Runs one search; guesses expected by the caller are already in exp_q.
   task automatic run_search(input int secret, input int delay,
                             input int lie_idx, input logic [2:0] lie_ans,
                             input bit poke, input bit exp_err,
                             input int exp_res, input int exp_probes);
      int idx = 0;
      int g;
      start = 1'b1;
      tick();
      start = 1'b0;
      total++;
      if (busy !== 1'b1 || done !== 1'b0 || err !== 1'b0)
         $display("FAIL search_begin: busy=%0b done=%0b err=%0b, required 1 0 0", busy, done, err);
      else passed++;
      while (exp_q.size() > 0) begin
         g = exp_q.pop_front();
         total++;
         if (req !== 1'b1 || guess !== g[2:0])
            $display("FAIL probe_guess[%0d]: req=%0b guess=%0d, required req=1 guess=%0d", idx, req, guess, g);
         else passed++;
         for (int d = 0; d < delay; d++) begin
            if (poke && d == 0) start = 1'b1;
            tick();
            start = 1'b0;
            total++;
            if (req !== 1'b1 || guess !== g[2:0] || probes !== idx[2:0])
               $display("FAIL wait_hold[%0d]: req=%0b guess=%0d probes=%0d, required 1 %0d %0d",
                        idx, req, guess, probes, g, idx);
            else passed++;
         end
         ack = 1'b1;
         if (idx == lie_idx) {eq, lt, gt} = lie_ans;
         else {eq, lt, gt} = {g == secret, g < secret, g > secret};
         tick();
         {ack, eq, lt, gt} = 4'b0;
         idx++;
      end
      total++;
      if (done !== !exp_err || err !== exp_err || req !== 1'b0 || busy !== 1'b0 ||
          result !== exp_res[2:0] || probes !== exp_probes[2:0])
         $display("FAIL search_end(secret=%0d): done=%0b err=%0b req=%0b busy=%0b result=%0d probes=%0d, required done=%0b err=%0b req=0 busy=0 result=%0d probes=%0d",
                  secret, done, err, req, busy, result, probes, !exp_err, exp_err, exp_res, exp_probes);
      else passed++;
      tick();
      total++;
      if (done !== !exp_err || err !== exp_err || result !== exp_res[2:0] || probes !== exp_probes[2:0])
         $display("FAIL end_hold(secret=%0d): done=%0b err=%0b result=%0d probes=%0d", secret, done, err, result, probes);
      else passed++;
   endtask

   task automatic test_reset();
      #2;
      check_idle_outputs("reset_asserted");
      tick();
      rst = 1'b0;
      tick();
      check_idle_outputs("after_release");
   endtask

   task automatic test_basic();
      exp_q = '{3, 5};          run_search(5, 0, -1, 3'b000, 0, 0, 5, 2);
      exp_q = '{3, 5, 6, 7};    run_search(7, 0, -1, 3'b000, 0, 0, 7, 4);
      exp_q = '{3, 1, 0};       run_search(0, 0, -1, 3'b000, 0, 0, 0, 3);
   endtask

   task automatic test_delay();
      exp_q = '{3, 1, 2};       run_search(2, 3, -1, 3'b000, 0, 0, 2, 3);
   endtask

   task automatic test_errors();
      exp_q = '{3};             run_search(5, 0, 0, 3'b110, 0, 1, 0, 1);
      exp_q = '{3, 5, 6, 7};    run_search(7, 0, 3, 3'b010, 0, 1, 0, 4);
      exp_q = '{3, 1, 0};       run_search(0, 0, 2, 3'b001, 0, 1, 0, 3);
      exp_q = '{3};             run_search(3, 0, 0, 3'b000, 0, 1, 0, 1);
   endtask

   task automatic test_rst_mid_search();
      start = 1'b1;
      tick();
      start = 1'b0;
      ack = 1'b1; {eq, lt, gt} = 3'b010;
      tick();
      {ack, eq, lt, gt} = 4'b0;
      total++;
      if (req !== 1'b1 || guess !== 3'd5)
         $display("FAIL pre_rst_guess: req=%0b guess=%0d, required 1 5", req, guess);
      else passed++;
      #2 rst = 1'b1;
      #1;
      check_idle_outputs("async_rst");
      tick();
      rst = 1'b0;
      ack = 1'b1; eq = 1'b1;
      tick();
      {ack, eq} = 2'b0;
      check_idle_outputs("ack_in_idle");
      exp_q = '{3, 5, 4};       run_search(4, 0, -1, 3'b000, 0, 0, 4, 3);
   endtask

   task automatic test_back_to_back();
      exp_q = '{3, 5, 6};       run_search(6, 2, -1, 3'b000, 1, 0, 6, 3);
      exp_q = '{3, 1};          run_search(1, 0, -1, 3'b000, 0, 0, 1, 2);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_delay();
      test_errors();
      test_rst_mid_search();
      test_back_to_back();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   always @(negedge clk) begin
      if (!rst && done && err) begin
         total++;
         $display("FAIL done_err_exclusive: done=%0b err=%0b", done, err);
      end
   end

endmodule
